// File: rtl/accumulation_buffer_controller.sv
// Sequences the double-banked accumulation buffer: read-modify-write accumulation into
// the active bank, drain of the retired bank over ready/valid, and bank switching.
module accumulation_buffer_controller #(
    parameter int DATA_WIDTH      = 64,
    parameter int BANK_ADDR_WIDTH = 6,
    parameter int BANK_DEPTH      = 36
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic                       acc_first,
    input  logic [BANK_ADDR_WIDTH-1:0] acc_adr,
    input  logic [DATA_WIDTH-1:0]      acc_data,
    input  logic                       tile_done,
    input  logic [BANK_ADDR_WIDTH:0]   drain_count,
    output logic                       ab_switch_banks,
    output logic                       ab_ren,
    output logic [BANK_ADDR_WIDTH-1:0] ab_radr,
    input  logic [DATA_WIDTH-1:0]      ab_rdata,
    output logic                       ab_wen,
    output logic [BANK_ADDR_WIDTH-1:0] ab_wadr,
    output logic [DATA_WIDTH-1:0]      ab_wdata,
    output logic                       ab_ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] ab_radr_wb,
    input  logic [DATA_WIDTH-1:0]      ab_rdata_wb,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       drain_done
);
    localparam logic [BANK_ADDR_WIDTH:0] MAX_COUNT = (BANK_ADDR_WIDTH+1)'(BANK_DEPTH);

    typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_WAIT_DRAIN, ST_SWITCH} state_t;

    state_t                      state_reg, state_next;
    logic [BANK_ADDR_WIDTH:0]    count_reg;
    logic                        acc_fire, tile_fire;

    logic                        s1_valid_reg, s1_first_reg;
    logic [BANK_ADDR_WIDTH-1:0]  s1_adr_reg;
    logic [DATA_WIDTH-1:0]       s1_data_reg;
    logic                        fwd_valid_reg;
    logic [BANK_ADDR_WIDTH-1:0]  fwd_adr_reg;
    logic [DATA_WIDTH-1:0]       fwd_data_reg;
    logic                        fwd_hit;
    logic [DATA_WIDTH-1:0]       operand, acc_result;

    logic                        drain_active_reg, inflight_reg, drain_done_reg;
    logic [BANK_ADDR_WIDTH:0]    rd_adr_reg, drain_cnt_reg;
    logic [DATA_WIDTH-1:0]       fifo_mem_reg [2];
    logic                        fifo_wptr_reg, fifo_rptr_reg;
    logic [1:0]                  fifo_cnt_reg;
    logic                        push, pop, issue, last_beat;
    logic [2:0]                  occ_total;

    assign acc_fire  = acc_valid && acc_ready && !rst;
    assign tile_fire = tile_done && acc_ready && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_ACC;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (tile_fire)
                count_reg <= (drain_count > MAX_COUNT) ? MAX_COUNT : drain_count;
        end
    end

    // FLUSH lasts one cycle: nothing is accepted there, so S1 empties by its end.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_ACC:        if (tile_fire) state_next = ST_FLUSH;
            ST_FLUSH:      state_next = ST_WAIT_DRAIN;
            ST_WAIT_DRAIN: if (!drain_active_reg) state_next = ST_SWITCH;
            ST_SWITCH:     state_next = ST_ACC;
            default:       state_next = ST_ACC;
        endcase
    end

    always_comb begin
        acc_ready       = rst || (state_reg == ST_ACC);
        ab_switch_banks = !rst && (state_reg == ST_SWITCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_first_reg  <= 1'b0;
            s1_adr_reg    <= '0;
            s1_data_reg   <= '0;
            fwd_valid_reg <= 1'b0;
            fwd_adr_reg   <= '0;
            fwd_data_reg  <= '0;
        end else begin
            s1_valid_reg <= acc_fire;
            if (acc_fire) begin
                s1_first_reg <= acc_first;
                s1_adr_reg   <= acc_adr;
                s1_data_reg  <= acc_data;
            end
            fwd_valid_reg <= ab_wen && (state_reg != ST_SWITCH);
            fwd_adr_reg   <= ab_wadr;
            fwd_data_reg  <= ab_wdata;
        end
    end

    // The buffer returns the old value on a same-cycle read/write, so the last write is forwarded.
    always_comb begin
        fwd_hit    = fwd_valid_reg && (fwd_adr_reg == s1_adr_reg);
        operand    = fwd_hit ? fwd_data_reg : ab_rdata;
        acc_result = s1_first_reg ? s1_data_reg : operand + s1_data_reg;
        ab_ren     = acc_fire;
        ab_radr    = acc_fire ? acc_adr : '0;
        ab_wen     = s1_valid_reg && !rst;
        ab_wadr    = ab_wen ? s1_adr_reg : '0;
        ab_wdata   = ab_wen ? acc_result : '0;
    end

    // A read may issue only if its data is guaranteed a FIFO slot when it returns.
    always_comb begin
        out_valid  = !rst && (fifo_cnt_reg != 2'd0);
        out_data   = out_valid ? fifo_mem_reg[fifo_rptr_reg] : '0;
        pop        = out_valid && out_ready;
        push       = inflight_reg;
        occ_total  = {1'b0, fifo_cnt_reg} - {2'b0, pop} + {2'b0, inflight_reg};
        issue      = !rst && drain_active_reg && (rd_adr_reg < drain_cnt_reg) && (occ_total < 3'd2);
        ab_ren_wb  = issue;
        ab_radr_wb = issue ? rd_adr_reg[BANK_ADDR_WIDTH-1:0] : '0;
        last_beat  = pop && (fifo_cnt_reg == 2'd1) && !inflight_reg && (rd_adr_reg == drain_cnt_reg);
        drain_done = drain_done_reg && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_active_reg <= 1'b0;
            drain_done_reg   <= 1'b0;
            inflight_reg     <= 1'b0;
            rd_adr_reg       <= '0;
            drain_cnt_reg    <= '0;
            fifo_wptr_reg    <= 1'b0;
            fifo_rptr_reg    <= 1'b0;
            fifo_cnt_reg     <= 2'd0;
        end else begin
            drain_done_reg <= 1'b0;
            if (state_reg == ST_SWITCH) begin
                rd_adr_reg    <= '0;
                drain_cnt_reg <= count_reg;
                if (count_reg == '0)
                    drain_done_reg <= 1'b1;
                else
                    drain_active_reg <= 1'b1;
            end else if (drain_active_reg) begin
                if (issue)
                    rd_adr_reg <= rd_adr_reg + 1'b1;
                if (last_beat) begin
                    drain_active_reg <= 1'b0;
                    drain_done_reg   <= 1'b1;
                end
            end
            inflight_reg <= issue;
            if (push)
                fifo_wptr_reg <= ~fifo_wptr_reg;
            if (pop)
                fifo_rptr_reg <= ~fifo_rptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (push && (fifo_wptr_reg == 1'(gi)))
                    fifo_mem_reg[gi] <= ab_rdata_wb;
            end
        end
    endgenerate
endmodule

// File: tb/tb_accumulation_buffer_controller.sv
// Randomized bench for accumulation_buffer_controller: a two-bank buffer emulation plus a
// logical-bank accumulation model and a drain scoreboard.
module tb_accumulation_buffer_controller;
    localparam int DW = 64;
    localparam int AW = 6;
    localparam int DEPTH = 36;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          acc_valid = 1'b0, acc_ready, acc_first = 1'b0, tile_done = 1'b0;
    logic [AW-1:0] acc_adr = '0;
    logic [DW-1:0] acc_data = '0;
    logic [AW:0]   drain_count = '0;
    logic          ab_switch_banks, ab_ren, ab_wen, ab_ren_wb;
    logic [AW-1:0] ab_radr, ab_wadr, ab_radr_wb;
    logic [DW-1:0] ab_rdata = '0, ab_wdata, ab_rdata_wb = '0;
    logic          out_valid, out_ready, drain_done;
    logic [DW-1:0] out_data;

    accumulation_buffer_controller #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .BANK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_first(acc_first),
        .acc_adr(acc_adr), .acc_data(acc_data),
        .tile_done(tile_done), .drain_count(drain_count),
        .ab_switch_banks(ab_switch_banks),
        .ab_ren(ab_ren), .ab_radr(ab_radr), .ab_rdata(ab_rdata),
        .ab_wen(ab_wen), .ab_wadr(ab_wadr), .ab_wdata(ab_wdata),
        .ab_ren_wb(ab_ren_wb), .ab_radr_wb(ab_radr_wb), .ab_rdata_wb(ab_rdata_wb),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Buffer emulation: physical banks, 1-cycle reads returning the pre-write value.
    logic [DW-1:0] init_val [2][DEPTH];
    logic [DW-1:0] mem [2][DEPTH];
    bit            mem_act = 1'b0;
    bit            mem_ready = 1'b0;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++)
                init_val[b][i] = {$urandom(), $urandom()};
    end

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < DEPTH; i++)
                    mem[b][i] = init_val[b][i];
            mem_ready = 1'b1;
        end
        if (ab_ren && ab_radr < DEPTH) ab_rdata <= mem[mem_act][ab_radr];
        if (ab_ren_wb && ab_radr_wb < DEPTH) ab_rdata_wb <= mem[!mem_act][ab_radr_wb];
        if (ab_wen && ab_wadr < DEPTH) mem[mem_act][ab_wadr] = ab_wdata;
        if (ab_switch_banks) mem_act <= !mem_act;
    end

    // Reference model: logical bank contents and the expected drain stream.
    logic [DW-1:0] shadow [2][DEPTH];
    bit            shadow_ready = 1'b0;
    int            sidx = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] drained [DEPTH];
    bit            pending = 0, drain_busy = 0, exp_done_now = 0, done_next = 0;
    bit            prev_stall = 0, prev_switch = 0;
    logic [DW-1:0] prev_data = '0;
    int            pend_cnt = 0, beats_left = 0, beat_idx = 0, switch_cnt = 0;
    int            cyc = 0, first_cyc = 0, last_cyc = 0;
    int            rdy_mode = 0;

    always @(negedge clk) begin
        logic [DW-1:0] e;
        cyc++;
        if (!shadow_ready) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < DEPTH; i++)
                    shadow[b][i] = init_val[b][i];
            shadow_ready = 1'b1;
        end
        if (rst) begin
            exp_q.delete();
            pending = 0; drain_busy = 0; exp_done_now = 0; done_next = 0;
            prev_stall = 0; prev_switch = 0;
        end else begin
            check("drain_done", drain_done, exp_done_now);
            if (pending) check("acc_ready_blocked", acc_ready, 0);
            if (prev_switch) check("acc_ready_after_switch", acc_ready, 1);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (ab_switch_banks) begin
                check("switch_legal", {pending, drain_busy, ab_wen, ab_ren, ab_ren_wb}, 5'b10000);
                switch_cnt++;
                pending = 0;
                beat_idx = 0;
                if (pend_cnt == 0) done_next = 1;
                else begin drain_busy = 1; beats_left = pend_cnt; end
            end
            if (out_valid && out_ready) begin
                if (!drain_busy || exp_q.size() == 0) begin
                    check("beat_unexpected", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e);
                    if (beat_idx < DEPTH) drained[beat_idx] = out_data;
                    if (beat_idx == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beat_idx++;
                    beats_left--;
                    if (beats_left == 0) begin
                        drain_busy = 0;
                        done_next = 1;
                        $display("drain complete: %0d beats at cycle %0d", beat_idx, cyc);
                    end
                end
            end
            if (acc_valid && acc_ready) begin
                if (acc_first) shadow[sidx][acc_adr] = acc_data;
                else shadow[sidx][acc_adr] = shadow[sidx][acc_adr] + acc_data;
            end
            if (tile_done && acc_ready) begin
                for (int i = 0; i < int'(drain_count); i++) exp_q.push_back(shadow[sidx][i]);
                pend_cnt = int'(drain_count);
                pending = 1;
                sidx = 1 - sidx;
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_switch = ab_switch_banks;
            exp_done_now = done_next;
            done_next = 0;
        end
    end

    // out_ready: 0 = always ready, 1 = 50% random, 2 = pattern 1,0,0,1, 3 = 25% random
    initial begin
        logic [3:0] pat;
        int pidx;
        pat = 4'b1001;
        pidx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: out_ready = ($urandom_range(0, 1) == 1);
                2: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 4; end
                3: out_ready = ($urandom_range(0, 3) == 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic drive(input logic v, input logic f, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic td, input logic [AW:0] cnt);
        int n;
        bit took;
        acc_valid = v; acc_first = f; acc_adr = a; acc_data = d;
        tile_done = td; drain_count = cnt;
        n = 0;
        took = 0;
        while (!took && n < 1000) begin
            @(negedge clk);
            took = acc_ready || !(v || td);
            @(posedge clk);
            #1;
            n++;
        end
        check("drive_accepted", took, 1);
        acc_valid = 0; acc_first = 0; tile_done = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pending || drain_busy || exp_done_now || done_next) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {pending, drain_busy}, 0);
        check("exp_q_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_switch();
        int n;
        n = 0;
        while (pending && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("switch_reached", pending, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sw0, nops;
        logic [AW-1:0] a;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_acc_ready", acc_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {ab_wen, ab_ren_wb, ab_switch_banks, drain_done}, 0);
        @(posedge clk);
        #1;

        // Back-to-back accumulation into one address.
        rdy_mode = 0;
        drive(1, 1, 6'd5, 64'd10, 0, 0);
        drive(1, 0, 6'd5, 64'd7, 0, 0);
        drive(1, 0, 6'd5, 64'd3, 0, 0);
        drive(0, 0, 6'd0, 64'd0, 1, 7'd6);
        wait_idle();
        check("t1_beat5", drained[5], 64'd20);
        check("t1_beats", beat_idx, 6);

        // Alternating addresses: same-address updates two cycles apart.
        for (int i = 0; i < 8; i++)
            drive(1, i < 2, AW'(2 + i % 2), 64'd1, 0, 0);
        drive(0, 0, 6'd0, 64'd0, 1, 7'd4);
        wait_idle();
        check("t2_adr2", drained[2], 64'd4);
        check("t2_adr3", drained[3], 64'd4);

        // Full-bank drain at full throughput.
        rdy_mode = 0;
        drive(0, 0, 6'd0, 64'd0, 1, 7'd36);
        wait_idle();
        check("t3_beats", beat_idx, 36);
        check("t3_span", last_cyc - first_cyc, 35);

        // Drain under a 1,0,0,1 ready pattern.
        rdy_mode = 2;
        drive(1, 0, 6'd35, 64'h1234, 0, 0);
        drive(0, 0, 6'd0, 64'd0, 1, 7'd36);
        wait_idle();
        check("t4_beats", beat_idx, 36);

        // tile_done while the previous drain is still streaming.
        rdy_mode = 3;
        drive(0, 0, 6'd0, 64'd0, 1, 7'd36);
        wait_switch();
        sw0 = switch_cnt;
        for (int i = 0; i < 4; i++) drive(1, 0, AW'(i), {$urandom(), $urandom()}, 0, 0);
        drive(1, 0, 6'd7, 64'd9, 1, 7'd8);
        wait_idle();
        check("t5_switches", switch_cnt - sw0, 1);
        check("t5_beats", beat_idx, 8);

        // Randomized tiles, overlapping drains with accumulation.
        for (int t = 0; t < 8; t++) begin
            rdy_mode = $urandom_range(0, 3);
            nops = $urandom_range(0, 24);
            for (int k = 0; k < nops; k++) begin
                a = (t % 2 == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 4) == 0) drive(0, 0, 6'd0, 64'd0, 0, 0);
                else drive(1, $urandom_range(0, 3) == 0, a, {$urandom(), $urandom()}, 0, 0);
            end
            a = AW'($urandom_range(0, DEPTH - 1));
            drive(1, 0, a, {$urandom(), $urandom()}, 1, (AW+1)'($urandom_range(0, DEPTH)));
        end
        wait_idle();

        // Reset mid-drain and mid-accumulate.
        rdy_mode = 0;
        drive(0, 0, 6'd0, 64'd0, 1, 7'd36);
        wait_switch();
        for (int i = 0; i < 4; i++) drive(1, 0, AW'(10 + i), 64'd5, 0, 0);
        rst = 1'b1;
        acc_valid = 1'b1;
        acc_adr = 6'd15;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_ab_wen", ab_wen, 0);
        check("rst_acc_ready", acc_ready, 1);
        check("rst_quiet", {ab_switch_banks, drain_done, ab_ren_wb}, 0);
        @(posedge clk);
        #1;
        drive(1, 1, 6'd0, 64'hAB, 0, 0);
        drive(0, 0, 6'd0, 64'd0, 1, 7'd1);
        wait_idle();
        check("rst_readback", drained[0], 64'hAB);
        check("rst_beats", beat_idx, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
